// File: rtl/block_ram_dual_client_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : block_ram_pkg
//  Description : Shared constants and credit helper for the dual-client
//                block RAM front end.
//  Revision    : 1.0  initial release
// ============================================================================
package block_ram_pkg;

    localparam int RESP_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(RESP_DEPTH + 1);

    // True when one more response can be guaranteed a FIFO slot.
    function automatic logic credit_avail(input logic [OCC_WIDTH-1:0] occ,
                                          input logic                 inflight);
        return ({1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight}) < (OCC_WIDTH + 1)'(RESP_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_ram_dual_client_if.sv
`default_nettype none
// ============================================================================
//  Module      : block_ram_dual_client_if
//  Description : One client's request and response valid/ready streams.
//  Revision    : 1.0  initial release
// ============================================================================
interface block_ram_dual_client_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BE_WIDTH-1:0]   req_be;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/block_ram_dual_client_resp_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : resp_fifo2
//  Description : Two-entry ordered response FIFO with occupancy output.
//  Revision    : 1.0  initial release
// ============================================================================
module resp_fifo2
    import block_ram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enq_valid,
    input  logic [WIDTH-1:0]     i_enq_data,
    output logic                 o_deq_valid,
    input  logic                 i_deq_ready,
    output logic [WIDTH-1:0]     o_deq_data,
    output logic [OCC_WIDTH-1:0] o_occ
);
    localparam int PTR_WIDTH = $clog2(RESP_DEPTH);

    logic [WIDTH-1:0]     mem_q [RESP_DEPTH];
    logic [WIDTH-1:0]     mem_d [RESP_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 w_deq;

    assign o_deq_valid = (occ_q != '0);
    assign w_deq       = o_deq_valid && i_deq_ready;
    assign o_deq_data  = mem_q[rd_ptr_q];
    assign o_occ       = occ_q;

    // Enqueue is unconditional: the caller's credit scheme rules out overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_enq_valid) begin
            mem_d[wr_ptr_q] = i_enq_data;
            wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (w_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        occ_d = occ_q + OCC_WIDTH'(i_enq_valid) - OCC_WIDTH'(w_deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/block_ram_dual_client.sv
`default_nettype none
// ============================================================================
//  Module      : block_ram_dual_client
//  Description : Dual valid/ready client front end for a true dual-port
//                byte-enable block RAM with 1-cycle read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module block_ram_dual_client
    import block_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    block_ram_dual_client_if.slave a_port,
    block_ram_dual_client_if.slave b_port,
    output logic [DATA_WIDTH-1:0] DI_A,
    output logic [ADDR_WIDTH-1:0] ADDR_A,
    output logic                  WE_A,
    output logic [BE_WIDTH-1:0]   BE_A,
    input  logic [DATA_WIDTH-1:0] DO_A,
    output logic [DATA_WIDTH-1:0] DI_B,
    output logic [ADDR_WIDTH-1:0] ADDR_B,
    output logic                  WE_B,
    output logic [BE_WIDTH-1:0]   BE_B,
    input  logic [DATA_WIDTH-1:0] DO_B
);
    typedef struct packed {
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } bram_req_t;

    bram_req_t            w_req_a, w_req_b;
    logic [OCC_WIDTH-1:0] w_occ_a, w_occ_b;
    logic                 w_deq_a, w_deq_b;
    logic                 w_credit_a, w_credit_b;
    logic                 w_fire_a, w_fire_b;
    logic                 w_conflict;
    logic                 inflight_a_q, inflight_a_d;
    logic                 inflight_b_q, inflight_b_d;

    assign w_req_a = '{we: a_port.req_we, be: a_port.req_be,
                       addr: a_port.req_addr, data: a_port.req_data};
    assign w_req_b = '{we: b_port.req_we, be: b_port.req_be,
                       addr: b_port.req_addr, data: b_port.req_data};

    // A dequeue this cycle frees a slot, so it counts as credit too.
    assign w_deq_a    = a_port.resp_valid && a_port.resp_ready;
    assign w_deq_b    = b_port.resp_valid && b_port.resp_ready;
    assign w_credit_a = credit_avail(w_occ_a, inflight_a_q) || w_deq_a;
    assign w_credit_b = credit_avail(w_occ_b, inflight_b_q) || w_deq_b;

    // A wins same-address conflicts involving a write; B retries next cycle.
    assign w_conflict = w_fire_a && b_port.req_valid
                     && (w_req_a.addr == w_req_b.addr)
                     && (w_req_a.we || w_req_b.we);

    assign a_port.req_ready = w_credit_a;
    assign b_port.req_ready = w_credit_b && !w_conflict;
    assign w_fire_a         = a_port.req_valid && a_port.req_ready;
    assign w_fire_b         = b_port.req_valid && b_port.req_ready;

    assign ADDR_A = w_req_a.addr;
    assign DI_A   = w_req_a.data;
    assign BE_A   = w_req_a.be;
    assign WE_A   = w_fire_a && w_req_a.we;
    assign ADDR_B = w_req_b.addr;
    assign DI_B   = w_req_b.data;
    assign BE_B   = w_req_b.be;
    assign WE_B   = w_fire_b && w_req_b.we;

    always_comb begin
        inflight_a_d = w_fire_a && !w_req_a.we;
        inflight_b_d = w_fire_b && !w_req_b.we;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inflight_a_q <= 1'b0;
            inflight_b_q <= 1'b0;
        end else begin
            inflight_a_q <= inflight_a_d;
            inflight_b_q <= inflight_b_d;
        end
    end

    resp_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo_a (
        .clk         (CLK),
        .rst         (RESET),
        .i_enq_valid (inflight_a_q),
        .i_enq_data  (DO_A),
        .o_deq_valid (a_port.resp_valid),
        .i_deq_ready (a_port.resp_ready),
        .o_deq_data  (a_port.resp_data),
        .o_occ       (w_occ_a)
    );

    resp_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo_b (
        .clk         (CLK),
        .rst         (RESET),
        .i_enq_valid (inflight_b_q),
        .i_enq_data  (DO_B),
        .o_deq_valid (b_port.resp_valid),
        .i_deq_ready (b_port.resp_ready),
        .o_deq_data  (b_port.resp_data),
        .o_occ       (w_occ_b)
    );

endmodule
`default_nettype wire
